washer_ctrl_multi: RTL



---
 rtl/washer_pkg.sv | 49 ++++
 rtl/washer_phase_timer.sv | 44 ++++
 rtl/washer_ctrl_multi.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/washer_pkg.sv
// Shared types and helpers for the multi-program washer controller.
// Build option WASHER_EXTRA_RINSE_EN is consumed by washer_ctrl_multi, not here.
package washer_pkg;

    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_READY = 6'b000010,
        S_SOAK  = 6'b000100,
        S_WASH  = 6'b001000,
        S_RINSE = 6'b010000,
        S_SPIN  = 6'b100000
    } state_t;

    localparam int PH_SOAK  = 0;
    localparam int PH_WASH  = 1;
    localparam int PH_RINSE = 2;
    localparam int PH_SPIN  = 3;
    localparam int NUM_PH   = 4;

    // Widest packed duration table the helpers accept.
    localparam int TBL_MAX_W = 256;

    function automatic logic [31:0] table_entry(input logic [TBL_MAX_W-1:0] tbl,
                                                input int mode_idx,
                                                input int min_w);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 32; b++) begin
            if (b < min_w && (mode_idx * min_w + b) < TBL_MAX_W)
                r[b] = tbl[mode_idx * min_w + b];
        end
        return r;
    endfunction

    function automatic logic [31:0] onehot_lowest(input logic [31:0] v);
        return v & (~v + 32'd1);
    endfunction

    function automatic int onehot_index(input logic [31:0] v);
        int idx;
        idx = 0;
        for (int b = 31; b >= 0; b--) begin
            if (v[b])
                idx = b;
        end
        return idx;
    endfunction

endpackage

// File: rtl/washer_phase_timer.sv
// Prescaler plus minute counter shared by all running phases; reports the
// phase terminal tick and minutes remaining against the supplied limit.
module washer_phase_timer #(
    parameter int TICKS_PER_MIN = 15360,
    parameter int MIN_W         = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             pause,
    input  logic [MIN_W-1:0] limit,
    output logic             terminal,
    output logic [MIN_W-1:0] mins_left
);

    localparam int              PS_W    = $clog2(TICKS_PER_MIN);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICKS_PER_MIN - 1);
    localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);
    localparam logic [MIN_W-1:0] MIN_ONE = MIN_W'(1);
    localparam logic [MIN_W-1:0] MIN_MAX = '1;

    logic [PS_W-1:0]  ps;
    logic [MIN_W-1:0] mins;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            ps   <= '0;
            mins <= '0;
        end else if (!pause) begin
            if (ps == PS_LAST) begin
                ps <= '0;
                if (mins != MIN_MAX)
                    mins <= mins + MIN_ONE;
            end else begin
                ps <= ps + PS_ONE;
            end
        end
    end

    // A zero-length phase is terminal on its first cycle.
    assign terminal  = (limit == '0) || ((ps == PS_LAST) && (mins == limit - MIN_ONE));
    assign mins_left = limit - mins;

endmodule

// File: rtl/washer_ctrl_multi.sv
// Multi-program washer controller with lid pause, cancel/coin-return and done pulse.
// Define WASHER_EXTRA_RINSE_EN to add i_extra_rinse and a second rinse pass.
module washer_ctrl_multi
    import washer_pkg::*;
#(
    parameter int                         NUM_MODES     = 3,
    parameter int                         TICKS_PER_MIN = 15360,
    parameter int                         MIN_W         = 6,
    parameter logic [NUM_MODES*MIN_W-1:0] SOAK_TBL      = {6'd10, 6'd8, 6'd5},
    parameter logic [NUM_MODES*MIN_W-1:0] WASH_TBL      = {6'd20, 6'd15, 6'd10},
    parameter logic [NUM_MODES*MIN_W-1:0] RINSE_TBL     = {6'd10, 6'd8, 6'd5},
    parameter logic [NUM_MODES*MIN_W-1:0] SPIN_TBL      = {6'd10, 6'd8, 6'd5}
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_coin,
    input  logic                 i_lid,
    input  logic                 i_cancel,
    input  logic [NUM_MODES-1:0] i_mode_sel,
`ifdef WASHER_EXTRA_RINSE_EN
    input  logic                 i_extra_rinse,
`endif
    output logic                 o_idle,
    output logic                 o_ready,
    output logic                 o_soak,
    output logic                 o_wash,
    output logic                 o_rinse,
    output logic                 o_spin,
    output logic                 o_waterinlet,
    output logic                 o_paused,
    output logic [NUM_MODES-1:0] o_mode,
    output logic [MIN_W-1:0]     o_mins_left,
    output logic                 o_coinreturn,
    output logic                 o_done
);

    state_t               state;
    logic                 running;
    logic                 advance;
    logic                 again;
    logic                 timer_clear;
    logic                 terminal;
    logic [MIN_W-1:0]     timer_left;
    logic [MIN_W-1:0]     limit;
    logic [NUM_MODES-1:0] sel_low;
    logic [MIN_W-1:0]     dur [NUM_PH];
    int                   mode_idx;

    assign running = (state == S_SOAK) || (state == S_WASH) ||
                     (state == S_RINSE) || (state == S_SPIN);
    assign advance = running && terminal && !i_lid;
    assign sel_low = NUM_MODES'(onehot_lowest(32'(i_mode_sel)));

    always_comb begin
        mode_idx       = onehot_index(32'(o_mode));
        dur[PH_SOAK]   = MIN_W'(table_entry(TBL_MAX_W'(SOAK_TBL),  mode_idx, MIN_W));
        dur[PH_WASH]   = MIN_W'(table_entry(TBL_MAX_W'(WASH_TBL),  mode_idx, MIN_W));
        dur[PH_RINSE]  = MIN_W'(table_entry(TBL_MAX_W'(RINSE_TBL), mode_idx, MIN_W));
        dur[PH_SPIN]   = MIN_W'(table_entry(TBL_MAX_W'(SPIN_TBL),  mode_idx, MIN_W));
        limit          = '0;
        case (state)
            S_SOAK:  limit = dur[PH_SOAK];
            S_WASH:  limit = dur[PH_WASH];
            S_RINSE: limit = dur[PH_RINSE];
            S_SPIN:  limit = dur[PH_SPIN];
            default: limit = '0;
        endcase
    end

    // Counters restart on every phase entry, including the second rinse pass.
    assign timer_clear = !running || advance || i_cancel;

    washer_phase_timer #(
        .TICKS_PER_MIN (TICKS_PER_MIN),
        .MIN_W         (MIN_W)
    ) u_timer (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .clear     (timer_clear),
        .pause     (i_lid),
        .limit     (limit),
        .terminal  (terminal),
        .mins_left (timer_left)
    );

`ifdef WASHER_EXTRA_RINSE_EN
    logic extra_q;
    logic pass2_q;
    assign again = extra_q && !pass2_q;
`else
    assign again = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            o_mode       <= '0;
            o_done       <= 1'b0;
            o_coinreturn <= 1'b0;
`ifdef WASHER_EXTRA_RINSE_EN
            extra_q      <= 1'b0;
            pass2_q      <= 1'b0;
`endif
        end else begin
            o_done       <= 1'b0;
            o_coinreturn <= 1'b0;
            if (i_cancel) begin
                state        <= S_IDLE;
                o_mode       <= '0;
                o_coinreturn <= (state == S_READY);
`ifdef WASHER_EXTRA_RINSE_EN
                extra_q      <= 1'b0;
                pass2_q      <= 1'b0;
`endif
            end else begin
                case (state)
                    S_IDLE: begin
                        if (i_coin && !i_lid)
                            state <= S_READY;
                    end
                    S_READY: begin
                        if (|i_mode_sel && !i_lid) begin
                            state  <= S_SOAK;
                            o_mode <= sel_low;
`ifdef WASHER_EXTRA_RINSE_EN
                            extra_q <= i_extra_rinse;
                            pass2_q <= 1'b0;
`endif
                        end
                    end
                    S_SOAK:  if (advance) state <= S_WASH;
                    S_WASH:  if (advance) state <= S_RINSE;
                    S_RINSE: begin
                        if (advance) begin
                            if (again) begin
`ifdef WASHER_EXTRA_RINSE_EN
                                pass2_q <= 1'b1;
`endif
                            end else begin
                                state <= S_SPIN;
                            end
                        end
                    end
                    S_SPIN: begin
                        if (advance) begin
                            state  <= S_IDLE;
                            o_mode <= '0;
                            o_done <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_idle       = (state == S_IDLE);
    assign o_ready      = (state == S_READY);
    assign o_soak       = (state == S_SOAK);
    assign o_wash       = (state == S_WASH);
    assign o_rinse      = (state == S_RINSE);
    assign o_spin       = (state == S_SPIN);
    assign o_waterinlet = o_soak || o_wash || o_rinse;
    assign o_paused     = running && i_lid;
    assign o_mins_left  = running ? timer_left : '0;

endmodule
